// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared FSM state type and default geometry for ctrl_rfseq
//
// Purpose : FSM state enum plus the default address width, channel count and
//           tap count used by the register-file sequencer and its interface.
// Ports   : none (package).
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CALC  = 2'd2,
    WBACK = 2'd3
  } state_t;

  localparam int DEF_AW   = 5;
  localparam int DEF_NCH  = 2;
  localparam int DEF_TAPS = 8;

endpackage

// File: rtl/ctrl_rfseq_if.sv
// rtl/ctrl_rfseq_if.sv - request/address bundle between a client and ctrl_rfseq
//
// Purpose : groups the request inputs (en, ch, push, calc) and the register
//           file address/strobe outputs of the sequencer.
// Ports   : master modport = client side (drives requests, reads addresses);
//           slave modport  = sequencer side.
interface ctrl_rfseq_if
  import ctrl_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int CW = 1
);

  logic          en;
  logic [CW-1:0] ch;
  logic          push;
  logic          calc;
  logic [AW-1:0] ar1;
  logic [AW-1:0] ar2;
  logic [AW-1:0] ard;
  logic          we;
  logic          rd_vld;
  logic          last;
  logic          done;
  logic          busy;

  modport master (
    output en, ch, push, calc,
    input  ar1, ar2, ard, we, rd_vld, last, done, busy
  );

  modport slave (
    input  en, ch, push, calc,
    output ar1, ar2, ard, we, rd_vld, last, done, busy
  );

endinterface

// File: rtl/ctrl_rfptr.sv
// rtl/ctrl_rfptr.sv - per-channel wrapping head pointers of the sample delay lines
//
// Purpose : NCH head pointers, each counting 0..TAPS-1 and wrapping to 0.
// Ports   : clk, rst (sync, active-high); inc bumps the pointer of channel ch;
//           head returns the current pointer of channel ch (0 for an
//           out-of-range channel).
module ctrl_rfptr #(
  parameter int NCH  = 2,
  parameter int TAPS = 8,
  parameter int CW   = 1,
  parameter int TW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [CW-1:0] ch,
  output logic [TW-1:0] head
);

  logic [TW-1:0] head_q [NCH];
  logic          ch_ok;

  assign ch_ok = int'(ch) < NCH;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) head_q[i] <= '0;
    end else if (inc && ch_ok) begin
      head_q[ch] <= (head_q[ch] == TW'(TAPS - 1)) ? '0 : head_q[ch] + TW'(1);
    end
  end

  assign head = ch_ok ? head_q[ch] : '0;

endmodule

// File: rtl/ctrl_rfseq.sv
// rtl/ctrl_rfseq.sv - register-file address sequencer for per-channel FIR MAC
//
// Purpose : stores samples into per-channel delay-line segments (push) and
//           sweeps TAPS sample/coefficient read pairs followed by a result
//           write-back (calc). Result slots sit above all delay lines at
//           NCH*TAPS + channel.
// Ports   : clk, rst (sync, active-high, overrides en);
//           bus (slave): en, ch, push, calc in; ar1, ar2, ard, we, rd_vld,
//           last, done, busy out, all registered.
module ctrl_rfseq
  import ctrl_pkg::*;
#(
  parameter  int AW   = DEF_AW,
  parameter  int NCH  = DEF_NCH,
  parameter  int TAPS = DEF_TAPS,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic         clk,
  input  logic         rst,
  ctrl_rfseq_if.slave  bus
);

  if (2 ** AW < NCH * TAPS + NCH) begin : g_aw_check
    $error("ctrl_rfseq: AW too small for NCH*TAPS+NCH addresses");
  end

  state_t        state_q, state_d;
  logic [TW-1:0] k_q, k_d, k_nx;
  logic [CW-1:0] c_q, c_d, rd_ch;
  logic [TW-1:0] head;
  logic          ptr_inc;

  logic [AW-1:0] ar1_q, ar1_d, ar2_q, ar2_d, ard_q, ard_d;
  logic          we_q, we_d, rd_vld_q, rd_vld_d, last_q, last_d;
  logic          done_q, done_d, busy_q, busy_d;

  // Newest sample sits at head-1; tap k walks backwards in time, modulo TAPS
  // inside the channel's own segment.
  function automatic logic [AW-1:0] samp_addr(input logic [CW-1:0] c,
                                              input logic [TW-1:0] h,
                                              input logic [TW-1:0] k);
    int idx;
    idx = int'(h) + TAPS - 1 - int'(k);
    if (idx >= TAPS) idx = idx - TAPS;
    return AW'(int'(c) * TAPS + idx);
  endfunction

  // Only IDLE looks at the live channel input; afterwards the latched one.
  assign rd_ch = (state_q == IDLE) ? bus.ch : c_q;
  assign k_nx  = k_q + TW'(1);

  ctrl_rfptr #(
    .NCH  (NCH),
    .TAPS (TAPS),
    .CW   (CW),
    .TW   (TW)
  ) u_rfptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (ptr_inc),
    .ch   (rd_ch),
    .head (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      c_q      <= '0;
      ar1_q    <= '0;
      ar2_q    <= '0;
      ard_q    <= '0;
      we_q     <= 1'b0;
      rd_vld_q <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      c_q      <= c_d;
      ar1_q    <= ar1_d;
      ar2_q    <= ar2_d;
      ard_q    <= ard_d;
      we_q     <= we_d;
      rd_vld_q <= rd_vld_d;
      last_q   <= last_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Outputs are computed for the state being entered. With en low everything
  // holds except the strobes, so a frozen sweep resumes on the next tap.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    c_d      = c_q;
    ptr_inc  = 1'b0;
    ar1_d    = ar1_q;
    ar2_d    = ar2_q;
    ard_d    = ard_q;
    we_d     = 1'b0;
    rd_vld_d = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    if (bus.en) begin
      ar1_d = '0;
      ar2_d = '0;
      ard_d = '0;
      case (state_q)
        IDLE: begin
          if (bus.push) begin
            state_d = LOAD;
            c_d     = bus.ch;
            ptr_inc = 1'b1;
            ard_d   = AW'(int'(bus.ch) * TAPS + int'(head));
            we_d    = 1'b1;
          end else if (bus.calc) begin
            state_d  = CALC;
            c_d      = bus.ch;
            k_d      = '0;
            ar1_d    = samp_addr(bus.ch, head, '0);
            rd_vld_d = 1'b1;
            last_d   = (TAPS == 1);
          end
        end
        LOAD: state_d = IDLE;
        CALC: begin
          if (k_q == TW'(TAPS - 1)) begin
            state_d = WBACK;
            k_d     = '0;
            ard_d   = AW'(NCH * TAPS + int'(c_q));
            we_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            k_d      = k_nx;
            ar1_d    = samp_addr(c_q, head, k_nx);
            ar2_d    = AW'(k_nx);
            rd_vld_d = 1'b1;
            last_d   = (k_nx == TW'(TAPS - 1));
          end
        end
        WBACK:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  assign bus.ar1    = ar1_q;
  assign bus.ar2    = ar2_q;
  assign bus.ard    = ard_q;
  assign bus.we     = we_q;
  assign bus.rd_vld = rd_vld_q;
  assign bus.last   = last_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_ctrl_rfseq.sv
// tb/tb_ctrl_rfseq.sv - directed self-checking bench for ctrl_rfseq (AW=5, NCH=2, TAPS=8)
module tb_ctrl_rfseq;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   busy_cnt;

  int   exp_c0 [8];
  int   exp_c1 [8];

  ctrl_rfseq_if #(.AW(5), .CW(1)) bus ();

  ctrl_rfseq #(.AW(5), .NCH(2), .TAPS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string tag, input int e1, input int e2, input int ed,
                          input bit ew, input bit ev, input bit el, input bit edn,
                          input bit eb);
    logic [19:0] obs;
    logic [19:0] exp;
    obs = {bus.ar1, bus.ar2, bus.ard, bus.we, bus.rd_vld, bus.last, bus.done, bus.busy};
    exp = {5'(e1), 5'(e2), 5'(ed), ew, ev, el, edn, eb};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (ar1,ar2,ard,we,rd_vld,last,done,busy)",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_o("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_chk(input bit c, input int ard_exp, input string tag);
    bus.ch   = c;
    bus.push = 1'b1;
    tick();
    bus.push = 1'b0;
    expect_o(tag, 0, 0, ard_exp, 1, 0, 0, 0, 1);
    tick();
    expect_o({tag, "_idle"}, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_c0 = '{2, 1, 0, 7, 6, 5, 4, 3};
    exp_c1 = '{9, 8, 15, 14, 13, 12, 11, 10};
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.ch   = 1'b0;
    bus.push = 1'b0;
    bus.calc = 1'b0;

    // reset held two cycles, first with en low to show rst overrides en
    tick();
    expect_o("rst_cyc1", 0, 0, 0, 0, 0, 0, 0, 0);
    bus.en = 1'b1;
    tick();
    expect_o("rst_cyc2", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // three pushes on ch0, one on ch1
    push_chk(1'b0, 0, "push_c0_0");
    push_chk(1'b0, 1, "push_c0_1");
    push_chk(1'b0, 2, "push_c0_2");
    push_chk(1'b1, 8, "push_c1_0");

    // calc sweep on ch0
    bus.ch   = 1'b0;
    bus.calc = 1'b1;
    tick();
    bus.calc = 1'b0;
    for (int k = 0; k < 8; k++) begin
      expect_o($sformatf("calc_c0_tap%0d", k), exp_c0[k], k, 0, 0, 1, k == 7, 0, 1);
      tick();
    end
    expect_o("calc_c0_wback", 0, 0, 16, 1, 0, 0, 1, 1);
    tick();
    expect_o("calc_c0_idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // nine pushes on ch1 from reset: wraps back to segment start
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push_chk(1'b1, 8 + (i % 8), $sformatf("wrap_push%0d", i));
    end

    // push and calc together: push only
    do_reset();
    bus.ch   = 1'b0;
    bus.push = 1'b1;
    bus.calc = 1'b1;
    tick();
    bus.push = 1'b0;
    bus.calc = 1'b0;
    expect_o("pc_load", 0, 0, 0, 1, 0, 0, 0, 1);
    tick();
    expect_o("pc_no_sweep1", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_o("pc_no_sweep2", 0, 0, 0, 0, 0, 0, 0, 0);

    // calc held high during the sweep is ignored; busy lasts 9 cycles
    bus.calc = 1'b1;
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (i == 0) expect_o("ign_tap0", 0, 0, 0, 0, 1, 0, 0, 1);
      if (i == 8) expect_o("ign_wback", 0, 0, 16, 1, 0, 0, 1, 1);
      if (i == 13) expect_o("ign_idle", 0, 0, 0, 0, 0, 0, 0, 0);
      bus.calc = (i < 6);
      tick();
    end
    total++;
    assert (busy_cnt == 9)
    else begin
      bad++;
      $error("FAIL busy_len observed=%0d expected=%0d", busy_cnt, 9);
    end

    // freeze mid-sweep, resume, then reset at tap 5
    do_reset();
    push_chk(1'b1, 8, "fz_push0");
    push_chk(1'b1, 9, "fz_push1");
    bus.ch   = 1'b1;
    bus.calc = 1'b1;
    tick();
    bus.calc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_o($sformatf("fz_tap%0d", k), exp_c1[k], k, 0, 0, 1, 0, 0, 1);
      if (k < 2) tick();
    end
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_o($sformatf("fz_hold%0d", i), exp_c1[2], 2, 0, 0, 0, 0, 0, 1);
    end
    bus.en = 1'b1;
    tick();
    expect_o("fz_resume_tap3", exp_c1[3], 3, 0, 0, 1, 0, 0, 1);
    tick();
    expect_o("fz_tap4", exp_c1[4], 4, 0, 0, 1, 0, 0, 1);
    tick();
    expect_o("fz_tap5", exp_c1[5], 5, 0, 0, 1, 0, 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_o("abort_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_o("abort_no_done", 0, 0, 0, 0, 0, 0, 0, 0);
    push_chk(1'b1, 8, "abort_head_cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_rfseq.md
CTRL_RFSEQ -- requirements
Module: ctrl_rfseq

Interface
REQ-001 SHALL have parameter AW, default 5: register-file address width.
REQ-002 SHALL have parameter NCH, default 2: number of channels, each with its own delay line.
REQ-003 SHALL have parameter TAPS, default 8: delay-line depth per channel, equal to the MAC sweep length.
REQ-004 SHALL have derived constant CW = max(1, clog2(NCH)); elaboration SHALL fail unless 2^AW >= NCH*TAPS+NCH.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 en  in  1  clock enable; low freezes all state.
REQ-008 ch  in  CW  channel select, sampled on request acceptance.
REQ-009 push  in  1  request to store a new sample into the channel delay line.
REQ-010 calc  in  1  request a TAPS-long MAC read sweep plus result write-back.
REQ-011 ar1  out  AW  sample read address.
REQ-012 ar2  out  AW  coefficient read address (tap index).
REQ-013 ard  out  AW  write address.
REQ-014 we  out  1  write strobe for ard.
REQ-015 rd_vld  out  1  ar1/ar2 valid this cycle.
REQ-016 last  out  1  final tap of the sweep.
REQ-017 done  out  1  one-cycle pulse on write-back.
REQ-018 busy  out  1  high whenever not IDLE.

Function
REQ-019 SHALL use FSM states IDLE, LOAD, CALC, WBACK; all outputs registered.
REQ-020 Requests SHALL be accepted only in IDLE with en=1; push and calc outside IDLE SHALL be ignored and not queued.
REQ-021 On simultaneous push and calc, push SHALL win and calc SHALL be dropped.
REQ-022 On push accepted at edge N, cycle N+1 SHALL be LOAD: ard = c*TAPS+head[c], we=1; head[c] SHALL increment, wrapping TAPS-1 -> 0; next state IDLE.
REQ-023 On calc accepted at edge N, cycles N+1..N+TAPS SHALL be CALC with tap k = 0..TAPS-1: ar1 = c*TAPS + ((head[c]-1-k) mod TAPS), ar2 = k, rd_vld=1, last=1 only at k=TAPS-1.
REQ-024 The cycle after the last tap SHALL be WBACK: ard = NCH*TAPS+c, we=1, done=1; next state IDLE.
REQ-025 Request-to-first-output latency SHALL be 1 cycle; calc occupancy SHALL be TAPS+1 cycles.
REQ-026 In states where they are unused, ar1/ar2/ard SHALL drive 0, and we/rd_vld/last/done SHALL be 0 (no tri-state).
REQ-027 With en=0, state, tap counter, heads and addresses SHALL hold; we/rd_vld/last/done SHALL be 0; the sequence SHALL resume on en=1 with no tap lost or repeated.
REQ-028 Address arithmetic SHALL be unsigned modulo TAPS within a channel segment, with no carry into adjacent segments.
REQ-029 A calc on a channel with fewer than TAPS pushes SHALL still sweep all TAPS slots.

Reset
REQ-030 On rst=1 at an edge: state IDLE, all head[] = 0, tap counter 0, all outputs 0; rst SHALL override en.
REQ-031 rst during LOAD, CALC or WBACK SHALL abort the operation with no we or done in the following cycle.

Structure
REQ-032 Package ctrl_pkg SHALL hold the FSM state enum and the default AW/NCH/TAPS constants.
REQ-033 Sub-module ctrl_rfptr SHALL implement the NCH-entry wrapping head-pointer array (increment on load, read by channel).

Verification (AW=5, NCH=2, TAPS=8)
REQ-034 Reset: rst=1 for 2 cycles -> all outputs 0, busy=0.
REQ-035 Three pushes on ch0, then one push on ch1 -> ard 0,1,2 then 8, one we pulse each.
REQ-036 After REQ-035, calc on ch0 -> ar1 = 2,1,0,7,6,5,4,3; ar2 = 0..7; last on the 8th tap; then ard=16, we=1, done=1.
REQ-037 Nine pushes on ch1 from reset -> ard 8..15, then 8 (wrap).
REQ-038 push and calc in the same cycle -> LOAD only, no sweep; calc during CALC -> ignored, busy stays high exactly 9 cycles.
REQ-039 en=0 for 3 cycles at tap 3 -> ar1/ar2 held, rd_vld=0, resumes at tap 3; rst at tap 5 -> IDLE next cycle, no done.
